// File: rtl/job_prog_slave.sv
// Bus-side responder for job programming: slot allocation, 8-word descriptor writes,
// barrier and status reads. Completed descriptors are queued for a load/store engine.
module job_prog_slave #(
  parameter int unsigned NB_JOBS    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req,
  input  logic [ADDR_WIDTH-1:0]   add,
  input  logic                    wen,
  input  logic [BE_WIDTH-1:0]     be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    gnt,
  output logic                    r_valid,
  output logic [DATA_WIDTH-1:0]   r_rdata,
  output logic                    job_valid_o,
  output logic [8*DATA_WIDTH-1:0] job_data_o,
  input  logic                    job_ready_i,
  input  logic                    job_done_i
);

  localparam int unsigned PtrW = $clog2(NB_JOBS);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned OutW = PtrW + 2;

  typedef enum logic [1:0] {StIdle, StFill, StBarWait} state_e;

  state_e state_q, state_d, ret_q, ret_d;

  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic [OutW-1:0]       out_q, out_d, pending;
  logic [2:0]            word_cnt_q;
  logic                  err_q;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
  logic [DATA_WIDTH-1:0] mem_q [NB_JOBS][8];

  logic       gnt_int, rd, wr, rd_alloc, rd_bar, rd_stat;
  logic       alloc_ok, wr_ok, wr_bad, commit, pop, done_ok, done_bad, bar_idle;
  logic       reserved, head_valid;
  logic [7:0] addr8;
  logic       unused_add;

  assign addr8      = add[7:0];
  assign unused_add = ^add[ADDR_WIDTH-1:8];

  // Only one transaction may be in flight while a barrier waits.
  assign gnt_int  = req & ~rst_i & (state_q != StBarWait);
  assign rd       = gnt_int & wen;
  assign wr       = gnt_int & ~wen;
  assign rd_alloc = rd & (addr8 == 8'h00);
  assign rd_bar   = rd & (addr8 == 8'h04);
  assign rd_stat  = rd & (addr8 == 8'h08);

  assign reserved   = (state_q == StFill) | ((state_q == StBarWait) & (ret_q == StFill));
  assign head_valid = (count_q != '0);

  assign alloc_ok = rd_alloc & (state_q == StIdle) & (count_q < CntW'(NB_JOBS));
  assign wr_ok    = wr & (state_q == StFill) & (be == '1);
  assign wr_bad   = wr & ~((state_q == StFill) & (be == '1));
  assign commit   = wr_ok & (word_cnt_q == 3'd7);
  assign pop      = head_valid & job_ready_i;

  // Popped-but-unfinished jobs; a done pulse with none of these is a protocol error.
  assign pending  = out_q - OutW'(count_q);
  assign done_ok  = job_done_i & (pending != '0);
  assign done_bad = job_done_i & (pending == '0);

  assign out_d    = out_q + OutW'(commit) - OutW'(done_ok);
  assign count_d  = count_q + CntW'(commit) - CntW'(pop);
  assign bar_idle = (out_d == '0);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ret_q   <= StIdle;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    unique case (state_q)
      StIdle: begin
        if (alloc_ok) begin
          state_d = StFill;
        end else if (rd_bar && !bar_idle) begin
          state_d = StBarWait;
          ret_d   = StIdle;
        end
      end
      StFill: begin
        if (commit) begin
          state_d = StIdle;
        end else if (rd_bar && !bar_idle) begin
          state_d = StBarWait;
          ret_d   = StFill;
        end
      end
      StBarWait: begin
        if (bar_idle) state_d = ret_q;
      end
      default: state_d = StIdle;
    endcase
  end

  // Response generation
  always_comb begin
    r_valid_d = 1'b0;
    r_rdata_d = '0;
    if (gnt_int) begin
      r_valid_d = rd_bar ? bar_idle : 1'b1;
      if (rd_alloc) begin
        r_rdata_d = alloc_ok ? DATA_WIDTH'(wr_ptr_q) : '1;
      end else if (rd_stat) begin
        r_rdata_d = DATA_WIDTH'({err_q, reserved, 8'(out_q), 8'(count_q)});
      end
    end else if (state_q == StBarWait && bar_idle) begin
      r_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      r_valid_q  <= 1'b0;
      r_rdata_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      count_q   <= count_d;
      out_q     <= out_d;
      if (commit) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (commit) begin
        word_cnt_q <= '0;
      end else if (wr_ok) begin
        word_cnt_q <= word_cnt_q + 3'd1;
      end
      // A new error in the same cycle as a STATUS read stays visible.
      if (wr_bad || done_bad) begin
        err_q <= 1'b1;
      end else if (rd_stat) begin
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q][word_cnt_q] <= wdata;
  end

  assign gnt         = gnt_int;
  assign r_valid     = r_valid_q & ~rst_i;
  assign r_rdata     = rst_i ? '0 : r_rdata_q;
  assign job_valid_o = head_valid & ~rst_i;

  always_comb begin
    job_data_o = '0;
    for (int k = 0; k < 8; k++) begin
      job_data_o[k*DATA_WIDTH +: DATA_WIDTH] = job_valid_o ? mem_q[rd_ptr_q][k] : '0;
    end
  end

endmodule
